// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_mem_pkg : address map and region type for the data memory      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_mem_pkg;

   localparam logic [31:0] c_RAM_LIMIT = 32'h0000_0100;
   localparam logic [31:0] c_IO_ADDR   = 32'h0000_0100;
   localparam logic [31:0] c_CNT_ADDR  = 32'h0000_0104;
   localparam logic [31:0] c_STAT_ADDR = 32'h0000_0108;

   typedef enum logic [2:0] {
      REGION_NONE = 3'd0,
      REGION_RAM  = 3'd1,
      REGION_IO   = 3'd2,
      REGION_CNT  = 3'd3,
      REGION_STAT = 3'd4
   } region_e;

endpackage
`default_nettype wire

// File: rtl/mmio_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_regs : IO output register, free-running cycle counter, sticky   |
// |             misalignment status.                  Rev 1.0            |
// +----------------------------------------------------------------------+
module mmio_regs #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_io_we,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_stat_clr,
   input  logic                  i_misalign,
   output logic [DATA_WIDTH-1:0] o_io,
   output logic [DATA_WIDTH-1:0] o_counter,
   output logic                  o_misalign_err
);

   logic [DATA_WIDTH-1:0] r_io;
   logic [DATA_WIDTH-1:0] r_counter;
   logic                  r_misalign_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_io           <= '0;
         r_counter      <= '0;
         r_misalign_err <= 1'b0;
      end else begin
         if (i_io_we) begin
            r_io <= i_wdata;
         end
         r_counter <= r_counter + DATA_WIDTH'(1);
         // A new error in the same cycle as a clear must survive
         if (i_misalign) begin
            r_misalign_err <= 1'b1;
         end else if (i_stat_clr) begin
            r_misalign_err <= 1'b0;
         end
      end
   end

   assign o_io           = r_io;
   assign o_counter      = r_counter;
   assign o_misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder : single-cycle data memory with RAM and MMIO      |
// |                      (IO, counter, status).       Rev 1.0            |
// +----------------------------------------------------------------------+
module data_mem_responder #(
   parameter int Data_Width     = 32,
   parameter int Mem_Depth      = 64,
   parameter int Mem_Addr_Width = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [Data_Width-1:0] ALUOut,
   input  logic [Data_Width-1:0] SecondRD,
   output logic [Data_Width-1:0] ReadData,
   output logic [Data_Width-1:0] IO_Out,
   output logic                  Misalign_Err
);

   import mips_mem_pkg::*;

   logic [Data_Width-1:0]     r_ram [Mem_Depth];
   region_e                   w_region;
   logic [Mem_Addr_Width-1:0] w_word_idx;
   logic                      w_aligned;
   logic                      w_misalign;
   logic                      w_wr_ok;
   logic                      w_ram_we;
   logic                      w_io_we;
   logic                      w_stat_clr;
   logic [Data_Width-1:0]     w_io;
   logic [Data_Width-1:0]     w_counter;

   always_comb begin
      w_region = REGION_NONE;
      if (ALUOut < Data_Width'(c_RAM_LIMIT)) begin
         w_region = REGION_RAM;
      end else if (ALUOut == Data_Width'(c_IO_ADDR)) begin
         w_region = REGION_IO;
      end else if (ALUOut == Data_Width'(c_CNT_ADDR)) begin
         w_region = REGION_CNT;
      end else if (ALUOut == Data_Width'(c_STAT_ADDR)) begin
         w_region = REGION_STAT;
      end
   end

   assign w_word_idx = ALUOut[Mem_Addr_Width+1:2];
   assign w_aligned  = (ALUOut[1:0] == 2'b00);
   assign w_misalign = (MemRead | MemWrite) & ~w_aligned;
   assign w_wr_ok    = MemWrite & w_aligned;
   assign w_ram_we   = w_wr_ok & (w_region == REGION_RAM);
   assign w_io_we    = w_wr_ok & (w_region == REGION_IO);
   assign w_stat_clr = w_wr_ok & (w_region == REGION_STAT) & SecondRD[0];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < Mem_Depth; i++) begin
            r_ram[i] <= '0;
         end
      end else if (w_ram_we) begin
         r_ram[w_word_idx] <= SecondRD;
      end
   end

   mmio_regs #(
      .DATA_WIDTH (Data_Width)
   ) u_mmio (
      .i_clk          (CLK),
      .i_rst          (RST),
      .i_io_we        (w_io_we),
      .i_wdata        (SecondRD),
      .i_stat_clr     (w_stat_clr),
      .i_misalign     (w_misalign),
      .o_io           (w_io),
      .o_counter      (w_counter),
      .o_misalign_err (Misalign_Err)
   );

   // Reads see pre-edge state, so a same-cycle write returns the old value
   always_comb begin
      ReadData = '0;
      if (MemRead && w_aligned) begin
         case (w_region)
            REGION_RAM:  ReadData = r_ram[w_word_idx];
            REGION_IO:   ReadData = w_io;
            REGION_CNT:  ReadData = w_counter;
            REGION_STAT: ReadData = {{(Data_Width-1){1'b0}}, Misalign_Err};
            default:     ReadData = '0;
         endcase
      end
   end

   assign IO_Out = w_io;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_responder : directed vectors with scoreboard checking    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_responder;

   localparam int c_K_RD = 0;
   localparam int c_K_IO = 1;
   localparam int c_K_ME = 2;

   typedef struct {
      int           cyc;
      int           kind;
      logic [127:0] name;
      logic [31:0]  val;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] ALUOut = '0;
   logic [31:0] SecondRD = '0;
   logic [31:0] ReadData;
   logic [31:0] IO_Out;
   logic        Misalign_Err;

   int   cyc = 0;
   int   base = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;
   logic [31:0] act;

   data_mem_responder #(
      .Data_Width     (32),
      .Mem_Depth      (64),
      .Mem_Addr_Width (6)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .ALUOut       (ALUOut),
      .SecondRD     (SecondRD),
      .ReadData     (ReadData),
      .IO_Out       (IO_Out),
      .Misalign_Err (Misalign_Err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: outputs are compared mid-cycle, on the falling edge
   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         case (e.kind)
            c_K_RD:  act = ReadData;
            c_K_IO:  act = IO_Out;
            default: act = {31'b0, Misalign_Err};
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %0s: got %h expected %h (cycle %0d)", e.name, act, e.val, e.cyc);
         end
      end
   end

   task automatic step(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd);
      @(posedge CLK);
      #2;
      MemWrite = we;
      MemRead  = re;
      ALUOut   = addr;
      SecondRD = wd;
   endtask

   task automatic expect_val(input int kind, input logic [127:0] name, input logic [31:0] val);
      exp_t x;
      x.cyc  = cyc;
      x.kind = kind;
      x.name = name;
      x.val  = val;
      sb.push_back(x);
   endtask

   initial begin
      // Reset state
      step(1'b0, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "rst_rd", 32'h0);
      expect_val(c_K_IO, "rst_io", 32'h0);
      expect_val(c_K_ME, "rst_me", 32'h0);

      step(1'b0, 1'b1, 32'h104, 32'h0);
      RST  = 1'b0;
      base = cyc;
      expect_val(c_K_RD, "cnt_first", 32'h0);
      step(1'b0, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "cnt_second", 32'h1);

      // Write-then-read, read-during-write
      step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      expect_val(c_K_RD, "wr_same_cyc", 32'h0);
      step(1'b0, 1'b1, 32'h10, 32'h0);
      expect_val(c_K_RD, "wr_next_cyc", 32'hDEADBEEF);
      step(1'b0, 1'b0, 32'h10, 32'h0);
      expect_val(c_K_RD, "rd_disabled", 32'h0);
      step(1'b0, 1'b1, 32'h200, 32'h0);
      expect_val(c_K_RD, "rd_unmapped", 32'h0);

      // Misaligned write
      step(1'b1, 1'b0, 32'h13, 32'h12345678);
      expect_val(c_K_ME, "mis_before", 32'h0);
      step(1'b0, 1'b1, 32'h10, 32'h0);
      expect_val(c_K_RD, "mis_ram_kept", 32'hDEADBEEF);
      expect_val(c_K_ME, "mis_set", 32'h1);
      step(1'b0, 1'b1, 32'h108, 32'h0);
      expect_val(c_K_RD, "stat_rd", 32'h1);

      // Clear attempt alongside a new misaligned access: set wins
      step(1'b1, 1'b1, 32'h109, 32'h1);
      expect_val(c_K_RD, "mis_rd_zero", 32'h0);
      step(1'b0, 1'b1, 32'h108, 32'h0);
      expect_val(c_K_RD, "set_wins_rd", 32'h1);
      expect_val(c_K_ME, "set_wins_me", 32'h1);
      step(1'b1, 1'b0, 32'h108, 32'h1);
      expect_val(c_K_ME, "clr_pending", 32'h1);
      step(1'b0, 1'b1, 32'h108, 32'h0);
      expect_val(c_K_RD, "clr_rd", 32'h0);
      expect_val(c_K_ME, "clr_me", 32'h0);

      // IO register and read-only counter
      step(1'b1, 1'b0, 32'h100, 32'h5A);
      expect_val(c_K_IO, "io_before", 32'h0);
      step(1'b0, 1'b1, 32'h100, 32'h0);
      expect_val(c_K_IO, "io_out", 32'h5A);
      expect_val(c_K_RD, "io_rd", 32'h5A);
      step(1'b1, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "cnt_wr_cyc", 32'(cyc - base));
      step(1'b0, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "cnt_after_wr", 32'(cyc - base));

      // Counter wrap
      step(1'b0, 1'b1, 32'h104, 32'h0);
      force dut.u_mmio.r_counter = 32'hFFFF_FFFF;
      #1;
      release dut.u_mmio.r_counter;
      base = cyc + 1;
      expect_val(c_K_RD, "cnt_forced", 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "cnt_wrap", 32'h0);

      // Mid-operation asynchronous reset
      step(1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
      step(1'b1, 1'b0, 32'h100, 32'h77);
      step(1'b0, 1'b1, 32'h1, 32'h0);
      step(1'b0, 1'b1, 32'h20, 32'h0);
      expect_val(c_K_RD, "pre_rst_rd", 32'hCAFEF00D);
      expect_val(c_K_IO, "pre_rst_io", 32'h77);
      expect_val(c_K_ME, "pre_rst_me", 32'h1);
      step(1'b1, 1'b1, 32'h20, 32'h11111111);
      #1;
      RST = 1'b1;
      expect_val(c_K_RD, "arst_rd", 32'h0);
      expect_val(c_K_IO, "arst_io", 32'h0);
      expect_val(c_K_ME, "arst_me", 32'h0);
      step(1'b0, 1'b1, 32'h20, 32'h0);
      RST  = 1'b0;
      base = cyc;
      expect_val(c_K_RD, "wr_discarded", 32'h0);
      step(1'b0, 1'b1, 32'h104, 32'h0);
      expect_val(c_K_RD, "cnt_restart", 32'h1);

      step(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter Data_Width, default 32, meaning the width of the data word and the address.
REQ-002 The block SHALL have parameter Mem_Depth, default 64, meaning the number of RAM words.
REQ-003 The block SHALL have parameter Mem_Addr_Width, default 6, meaning log2(Mem_Depth).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: store request this cycle.
REQ-007 The block SHALL have port MemRead, input, 1 bit: load request this cycle.
REQ-008 The block SHALL have port ALUOut, input, Data_Width bits: byte address from the datapath ALU.
REQ-009 The block SHALL have port SecondRD, input, Data_Width bits: store data.
REQ-010 The block SHALL have port ReadData, output, Data_Width bits: load data returned to the datapath.
REQ-011 The block SHALL have port IO_Out, output, Data_Width bits: memory-mapped output register.
REQ-012 The block SHALL have port Misalign_Err, output, 1 bit: sticky misaligned-access flag.

Function
REQ-013 Address map: 0x000-0x0FC = RAM word ALUOut[Mem_Addr_Width+1:2]; 0x100 = IO register (R/W); 0x104 = cycle counter (RO); 0x108 = status (bit0 = Misalign_Err, write-1-to-clear); all other addresses are unmapped.
REQ-014 Reads SHALL be combinational with zero latency: ReadData reflects ALUOut in the same cycle, as required by the single-cycle core.
REQ-015 When MemRead=0, when the address is unmapped, or when the access is misaligned, ReadData SHALL be 0.
REQ-016 When MemWrite=1 and the address is aligned and writable, the write SHALL commit on the rising edge of CLK; the write becomes visible to reads on the following cycle.
REQ-017 Read-during-write to the same address SHALL return the old value in that cycle.
REQ-018 A write SHALL be ignored when the address is unmapped, when it targets the counter (0x104), or when the access is misaligned.
REQ-019 Misaligned access: when (MemRead or MemWrite) and ALUOut[1:0]!=0, Misalign_Err SHALL be set on the next edge and remain set until cleared.
REQ-020 A write of SecondRD[0]=1 to 0x108 SHALL clear Misalign_Err; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-021 The cycle counter SHALL increment by 1 every cycle not in reset and SHALL wrap from 0xFFFFFFFF to 0.
REQ-022 MemRead=1 and MemWrite=1 in the same cycle SHALL be legal: the read returns the old data and the write commits.
REQ-023 IO_Out SHALL be driven directly by the IO register.

Reset
REQ-024 While RST=1, all RAM words, the IO register, the counter and Misalign_Err SHALL be 0, asynchronously.
REQ-025 Assertion of RST during a write cycle SHALL discard that write.
REQ-026 Once RST deasserts, the counter SHALL read 0 in the first cycle and 1 after the first edge.

Structure
REQ-027 The address-map constants (0x100, 0x104, 0x108, RAM_LIMIT=0x100) SHALL reside in a shared package mips_mem_pkg.
REQ-028 The IO register, counter and status register SHALL be placed in one sub-module, mmio_regs; the RAM array and decode SHALL be in the top level.

Verification
REQ-029 The bench SHALL cover this write-then-read case: write 0xDEADBEEF to 0x10; the same-cycle read returns 0; the next-cycle read returns 0xDEADBEEF.
REQ-030 The bench SHALL cover this misaligned-write case: write to 0x13 -> RAM is unchanged, Misalign_Err=1 after the edge, and a read of 0x108 returns 0x1.
REQ-031 The bench SHALL cover this clear-versus-set case: write 1 to 0x108 together with a misaligned read -> Misalign_Err stays 1; a later clear with no new error -> 0.
REQ-032 The bench SHALL cover the IO register and counter: write 0x5A to 0x100 -> IO_Out=0x5A next cycle; write to 0x104 -> the counter keeps incrementing and is unaffected.
REQ-033 The bench SHALL cover counter wrap: force the counter to 0xFFFFFFFF -> it reads 0 after one edge.
REQ-034 The bench SHALL cover mid-operation reset: assert RST asynchronously mid-cycle after writes -> all RAM reads, IO_Out and Misalign_Err are 0 immediately.
